// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for DIV/DIVU, returns {remainder, quotient}
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);
    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;
    localparam logic [5:0] LAST = 6'(WIDTH);
    state_t state, state_n;
    logic [5:0] cnt;
    logic [2*WIDTH:0] work;
    logic [WIDTH-1:0] divisor;
    logic neg_q, neg_r, accept, abort;
    logic [WIDTH:0] diff;
    logic [WIDTH-1:0] abs_a, abs_b, quot, rem;
    assign accept = start_i && !annul_i;
    assign abort = annul_i || !start_i;
    assign abs_a = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign abs_b = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    assign diff = {1'b0, work[2*WIDTH-1:WIDTH]} - {1'b0, divisor};
    assign quot = neg_q ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    assign rem = neg_r ? -work[2*WIDTH:WIDTH+1] : work[2*WIDTH:WIDTH+1];
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !accept ? IDLE : (opdata2_i == '0) ? BYZERO : ON;
            BYZERO:  state_n = END;
            ON:      state_n = abort ? IDLE : (cnt == LAST) ? END : ON;
            END:     state_n = start_i ? END : IDLE;
            default: state_n = IDLE;
        endcase
    end
    // ready_o is registered, so it rises one cycle after entering END
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt     <= '0;
                    work    <= {{WIDTH{1'b0}}, abs_a, 1'b0};
                    divisor <= abs_b;
                    neg_q   <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_r   <= signed_div_i && opdata1_i[WIDTH-1];
                end
                BYZERO: result_o <= '0;
                ON: if (!abort) begin
                    if (cnt != LAST) begin
                        work <= diff[WIDTH] ? {work[2*WIDTH-1:0], 1'b0}
                                            : {diff[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
                        cnt  <= cnt + 6'd1;
                    end else begin
                        result_o <= {rem, quot};
                        cnt      <= '0;
                    end
                end
                END: begin
                    ready_o <= start_i;
                    if (!start_i)
                        result_o <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized self-checking bench for div_seq against an arithmetic model
module tb_div_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    int n_checks = 0;
    int n_fail = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // MIPS semantics computed in 64-bit so the signed overflow case wraps cleanly
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return 64'd0;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp, held;
        int k;
        exp = model(sgn, a, b);
        @(negedge clk);
        signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        signed_div_i = $urandom; opdata1_i = $urandom; opdata2_i = $urandom;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!ready_o && k < 100);
        check($sformatf("latency %h/%h", a, b), 64'(k), (b == 0) ? 64'd2 : 64'd34);
        check($sformatf("result %0d %h/%h", sgn, a, b), result_o, exp);
        held = result_o;
        @(posedge clk); #1;
        check("end hold ready", 64'(ready_o), 64'd1);
        check("end hold result", result_o, held);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        check("drop ready", 64'(ready_o), 64'd0);
        check("drop result", result_o, 64'd0);
    endtask

    // start a divide, abort it at the tenth edge after acceptance by annul or by dropping start
    task automatic abort_div(input bit use_annul);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1; annul_i = 1'b0;
        @(posedge clk);
        repeat (9) begin
            @(posedge clk); #1;
            seen |= ready_o;
        end
        @(negedge clk);
        if (use_annul) annul_i = 1'b1; else start_i = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= ready_o;
            if (result_o != 0) seen = 1'b1;
            @(negedge clk);
            annul_i = 1'b0;
            start_i = 1'b0;
        end
        check(use_annul ? "annul no ready" : "drop no ready", 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        bit sgn;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_div(0, 32'd100, 32'd7);
        do_div(1, 32'hFFFFFFF9, 32'd2);
        do_div(1, 32'd7, 32'hFFFFFFFE);
        do_div(0, 32'd123, 32'd0);
        do_div(1, 32'hFFFFFF85, 32'd0);
        do_div(1, 32'h80000000, 32'hFFFFFFFF);
        do_div(0, 32'hFFFFFFFF, 32'd1);
        do_div(0, 32'd5, 32'd9);
        do_div(0, 32'h80000000, 32'hFFFFFFFF);
        abort_div(1);
        do_div(0, 32'd9, 32'd3);
        abort_div(0);
        do_div(0, 32'd9, 32'd3);
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd50000; opdata2_i = 32'd7; start_i = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst ready", 64'(ready_o), 64'd0);
        check("rst result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;
        do_div(0, 32'd1000, 32'd10);
        for (int i = 0; i < 40; i++) begin
            sgn = $urandom;
            a = $urandom;
            case ($urandom_range(3))
                0: b = $urandom_range(15);
                1: b = -$urandom_range(15);
                2: b = $urandom >> $urandom_range(31);
                default: b = $urandom;
            endcase
            do_div(sgn, a, b);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle divide sequencer for the EX stage. Serves DIV/DIVU, which stall the pipeline until the result is ready.
- Accepts operands via a level start/ready handshake and runs a restoring shift-subtract loop, one quotient bit per cycle.
- Handles divide-by-zero and signed pre/post correction. Supports annul from the pipeline flush logic.
- Returns {remainder, quotient} for the HI/LO write path.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start acceptance
opdata1_i  in  WIDTH  dividend; sampled at start acceptance
opdata2_i  in  WIDTH  divisor; sampled at start acceptance
start_i  in  1  level request from EX; held high until ready_o is seen
annul_i  in  1  flush of the instruction in EX; aborts an in-flight divide
result_o  out  2*WIDTH  [2W-1:W] = remainder (HI), [W-1:0] = quotient (LO)
ready_o  out  1  result valid; high only in state END

Behaviour:
- Reset: state IDLE, ready_o=0, result_o=0, cnt=0, work register=0. A reset mid-operation discards all progress.
- States: IDLE, BYZERO, ON, END. Registers: 6-bit cnt and a 2W+1-bit work register {partial remainder, dividend/quotient bits}.
- IDLE, start_i=1 and annul_i=0:
  - Latch signed_div_i.
  - If divisor==0, go to BYZERO.
  - Otherwise go to ON with cnt=0. Work register = {0, |dividend|, 1'b0}.
  - The stored divisor is |divisor|; absolute value is applied only when signed and MSB=1.
  - Input values are don't-care after the acceptance edge.
- IDLE with start_i=0 or annul_i=1: remain in IDLE.
- BYZERO: next state END; result_o=0.
- ON, cnt<WIDTH, one restoring step per cycle:
  - diff = work_hi - divisor (W+1 bits).
  - If diff is negative, shift work left by 1 with LSB 0.
  - Otherwise work = {diff, work_lo shifted left, 1}.
  - cnt increments.
- ON, cnt==WIDTH (correction cycle):
  - Quotient is negated iff signed and the operand MSBs differ.
  - Remainder is negated iff signed and the dividend MSB=1.
  - result_o = {remainder, quotient}; next state END; cnt=0.
- ON, annul_i=1 or start_i=0: abort to IDLE next cycle. ready_o stays 0; result_o is unchanged. Abort has priority over stepping.
- END: ready_o=1 and result_o held. If start_i=0, next state IDLE with ready_o=0 and result_o=0. Otherwise stay in END.
- annul_i in END is ignored; EX drops start_i itself.
- Latency, start accepted at edge t:
  - Normal divide: ready_o first high after edge t+WIDTH+2 (t+34 for W=32).
  - Divide-by-zero: ready_o first high after edge t+2.
- Arithmetic is two's complement with wrap. Signed 0x80000000/0xFFFFFFFF gives quotient 0x80000000, remainder 0, with no trap.
- Remainder magnitude is always less than |divisor|. Quotient is truncated toward zero (MIPS semantics).
- Back-to-back: after END→IDLE, a new start is accepted the following cycle. There is no acceptance in the same cycle as leaving END.

Test Plan:
- Unsigned 100/7, start held → ready_o rises at t+34; result_o = {0x00000002, 0x0000000E}. Drop start → ready_o=0 and result_o=0 next cycle.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0 (unsigned and signed) → ready_o at t+2, result_o=0.
- Edge values:
  - Signed 0x80000000/0xFFFFFFFF → {0, 0x80000000}.
  - Unsigned 0xFFFFFFFF/1 → {0, 0xFFFFFFFF}.
  - Unsigned 5/9 → {5, 0}.
- Annul at cycle t+10 → IDLE at t+11, ready_o never rises. Immediately start 9/3 → {0, 3} at its own t'+34. Same sequence with start_i dropped instead of annul.
- Assert rst at t+20 of a divide → all outputs 0 next cycle. A subsequent 1000/10 completes correctly with {0, 100}.
